// File: rtl/alu_pkg.sv
// ALU operation encoding shared by the controller and the datapath ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    C_ADD_U = 4'd0,
    C_SUB_U = 4'd1,
    C_MULT  = 4'd2,
    C_MUL_U = 4'd3,
    C_AND   = 4'd4,
    C_OR    = 4'd5,
    C_XOR   = 4'd6,
    C_SRL   = 4'd7,
    C_SLL   = 4'd8,
    C_SRA   = 4'd9,
    C_SLT   = 4'd10,
    C_SLTU  = 4'd11,
    C_BLEZ  = 4'd12,
    C_BGTZ  = 4'd13
  } alu_sel_t;

endpackage

// File: rtl/ctrl_pkg.sv
// Multicycle controller states, state classes for ALU decode, and MIPS
// opcode/funct field values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH       = 4'd0,
    DECODE      = 4'd1,
    EXEC_R      = 4'd2,
    EXEC_I      = 4'd3,
    MEM_ADDR    = 4'd4,
    MEM_RD      = 4'd5,
    MEM_RD_WAIT = 4'd6,
    MEM_WB      = 4'd7,
    MEM_WR      = 4'd8,
    R_WB        = 4'd9,
    I_WB        = 4'd10,
    MULT_WB     = 4'd11,
    BRANCH      = 4'd12,
    JUMP        = 4'd13,
    HALT        = 4'd14
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_MEM    = 3'd3,
    CLS_BRANCH = 3'd4
  } state_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SUBI  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic imm_is_signed(input logic [5:0] op);
    return !((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI));
  endfunction

  function automatic state_class_t state_class(input ctrl_state_t s);
    state_class_t c;
    case (s)
      EXEC_R:   c = CLS_R;
      EXEC_I:   c = CLS_I;
      MEM_ADDR: c = CLS_MEM;
      BRANCH:   c = CLS_BRANCH;
      default:  c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU operation select from the controller state class and the
// latched instruction fields.
module alu_ctrl
  import alu_pkg::*;
  import ctrl_pkg::*;
(
  input  state_class_t cls_i,
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output alu_sel_t     opsel_o
);

  always_comb begin
    opsel_o = C_ADD_U;
    case (cls_i)
      CLS_R: begin
        case (funct_i)
          FN_ADDU:  opsel_o = C_ADD_U;
          FN_SUBU:  opsel_o = C_SUB_U;
          FN_MULT:  opsel_o = C_MULT;
          FN_MULTU: opsel_o = C_MUL_U;
          FN_AND:   opsel_o = C_AND;
          FN_OR:    opsel_o = C_OR;
          FN_XOR:   opsel_o = C_XOR;
          FN_SRL:   opsel_o = C_SRL;
          FN_SLL:   opsel_o = C_SLL;
          FN_SRA:   opsel_o = C_SRA;
          FN_SLT:   opsel_o = C_SLT;
          FN_SLTU:  opsel_o = C_SLTU;
          default:  opsel_o = C_ADD_U;
        endcase
      end
      CLS_I: begin
        case (opcode_i)
          OP_ADDIU: opsel_o = C_ADD_U;
          OP_SUBI:  opsel_o = C_SUB_U;
          OP_ANDI:  opsel_o = C_AND;
          OP_ORI:   opsel_o = C_OR;
          OP_XORI:  opsel_o = C_XOR;
          OP_SLTI:  opsel_o = C_SLT;
          OP_SLTIU: opsel_o = C_SLTU;
          default:  opsel_o = C_ADD_U;
        endcase
      end
      CLS_BRANCH: begin
        case (opcode_i)
          OP_BEQ, OP_BNE: opsel_o = C_SUB_U;
          OP_BLEZ:        opsel_o = C_BLEZ;
          OP_BGTZ:        opsel_o = C_BGTZ;
          default:        opsel_o = C_ADD_U;
        endcase
      end
      default: opsel_o = C_ADD_U;
    endcase
  end

endmodule

// File: rtl/mips_ctrl.sv
// Multicycle MIPS control unit: Moore FSM whose outputs decode only from the
// current state and the opcode/funct captured in DECODE.
module mips_ctrl
  import alu_pkg::*;
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] ir_opcode,
  input  logic [5:0] ir_funct,
  input  logic       branch_taken,
  input  logic       alu_zero,
  output alu_sel_t   opsel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       is_signed,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ok,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       jump_and_link,
  output logic [1:0] alu_lo_hi,
  output logic       hi_en,
  output logic       lo_en,
  output logic       halted
);

  ctrl_state_t  state_q, state_d;
  logic [5:0]   op_q, op_d;
  logic [5:0]   fn_q, fn_d;
  state_class_t cls;

  assign cls = state_class(state_q);

  alu_ctrl u_alu_ctrl (
    .cls_i    (cls),
    .opcode_i (op_q),
    .funct_i  (fn_q),
    .opsel_o  (opsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  // IR is valid during DECODE, so dispatch reads it directly there; later
  // states use only the captured copy.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        op_d = ir_opcode;
        fn_d = ir_funct;
        case (ir_opcode)
          OP_RTYPE:                         state_d = EXEC_R;
          OP_LW, OP_SW:                     state_d = MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = BRANCH;
          OP_J, OP_JAL:                     state_d = JUMP;
          OP_HALT:                          state_d = HALT;
          OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI,
          OP_SUBI:                          state_d = EXEC_I;
          default:                          state_d = FETCH;
        endcase
      end
      EXEC_R: begin
        case (fn_q)
          FN_MULT, FN_MULTU: state_d = MULT_WB;
          FN_JR:             state_d = FETCH;
          default:           state_d = R_WB;
        endcase
      end
      EXEC_I:      state_d = I_WB;
      MEM_ADDR:    state_d = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:      state_d = MEM_RD_WAIT;
      MEM_RD_WAIT: state_d = MEM_WB;
      HALT:        state_d = HALT;
      default:     state_d = FETCH;
    endcase
  end

  // While rst_n is low every strobe is held off, even though the state
  // register already reads FETCH.
  always_comb begin
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    is_signed     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ok     = 1'b0;
    pc_source     = 2'd0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    jump_and_link = 1'b0;
    alu_lo_hi     = 2'd0;
    hi_en         = 1'b0;
    lo_en         = 1'b0;
    halted        = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
        DECODE: begin
          alu_src_b = 2'd3;
          is_signed = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          // jr: the datapath substitutes 0 for the constant when reg A is
          // the other operand, so the ALU passes rs straight to the PC.
          if (fn_q == FN_JR) begin
            alu_src_b = 2'd1;
            pc_write  = 1'b1;
          end
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          is_signed = imm_is_signed(op_q);
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          is_signed = 1'b1;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_RD_WAIT: i_or_d = 1'b1;
        MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          if (fn_q == FN_MFHI)      alu_lo_hi = 2'd2;
          else if (fn_q == FN_MFLO) alu_lo_hi = 2'd1;
        end
        I_WB: reg_write = 1'b1;
        MULT_WB: begin
          hi_en = 1'b1;
          lo_en = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          case (op_q)
            OP_BEQ:  branch_ok = alu_zero;
            OP_BNE:  branch_ok = !alu_zero;
            default: branch_ok = branch_taken;
          endcase
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          if (op_q == OP_JAL) begin
            jump_and_link = 1'b1;
            reg_write     = 1'b1;
          end
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ctrl.sv
// Scoreboard bench for mips_ctrl: stimulus queues the expected output vector
// for each cycle, a monitor compares it against the DUT on the falling edge.
module tb_mips_ctrl;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0] opsel;
    logic       src_a;
    logic [1:0] src_b;
    logic       sgn;
    logic       pcw;
    logic       pcwc;
    logic       bok;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       jal;
    logic [1:0] lohi;
    logic       hien;
    logic       loen;
    logic       hlt;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] ir_opcode = '0;
  logic [5:0] ir_funct = '0;
  logic       branch_taken = 1'b0;
  logic       alu_zero = 1'b0;

  alu_sel_t   opsel;
  logic       alu_src_a, is_signed, pc_write, pc_write_cond, branch_ok;
  logic [1:0] alu_src_b, pc_source, alu_lo_hi;
  logic       i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst;
  logic       mem_to_reg, jump_and_link, hi_en, lo_en, halted;

  mips_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ir_opcode     (ir_opcode),
    .ir_funct      (ir_funct),
    .branch_taken  (branch_taken),
    .alu_zero      (alu_zero),
    .opsel         (opsel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .is_signed     (is_signed),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ok     (branch_ok),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .jump_and_link (jump_and_link),
    .alu_lo_hi     (alu_lo_hi),
    .hi_en         (hi_en),
    .lo_en         (lo_en),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {opsel, alu_src_a, alu_src_b, is_signed, pc_write, pc_write_cond,
                branch_ok, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, jump_and_link, alu_lo_hi,
                hi_en, lo_en, halted};

  outs_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  done = 1'b0;

  // Expected output vectors, one builder per controller state.
  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.opsel = C_ADD_U;
    return o;
  endfunction

  function automatic outs_t e_fetch();
    outs_t o = base();
    o.mrd = 1'b1; o.irw = 1'b1; o.src_b = 2'd1; o.pcw = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_decode();
    outs_t o = base();
    o.src_b = 2'd3; o.sgn = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_exec_r(input logic [3:0] sel);
    outs_t o = base();
    o.opsel = sel; o.src_a = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_jr();
    outs_t o = base();
    o.src_a = 1'b1; o.src_b = 2'd1; o.pcw = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_rwb(input logic [1:0] lohi);
    outs_t o = base();
    o.rw = 1'b1; o.rdst = 1'b1; o.lohi = lohi;
    return o;
  endfunction

  function automatic outs_t e_mult_wb();
    outs_t o = base();
    o.hien = 1'b1; o.loen = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_exec_i(input logic [3:0] sel, input logic sgn);
    outs_t o = base();
    o.opsel = sel; o.src_a = 1'b1; o.src_b = 2'd2; o.sgn = sgn;
    return o;
  endfunction

  function automatic outs_t e_wb_rt(input logic from_mem);
    outs_t o = base();
    o.rw = 1'b1; o.m2r = from_mem;
    return o;
  endfunction

  function automatic outs_t e_mem_addr();
    outs_t o = base();
    o.src_a = 1'b1; o.src_b = 2'd2; o.sgn = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_mem(input logic rd, input logic wr);
    outs_t o = base();
    o.iord = 1'b1; o.mrd = rd; o.mwr = wr;
    return o;
  endfunction

  function automatic outs_t e_branch(input logic [3:0] sel, input logic ok);
    outs_t o = base();
    o.opsel = sel; o.src_a = 1'b1; o.pcwc = 1'b1; o.pcsrc = 2'd1; o.bok = ok;
    return o;
  endfunction

  function automatic outs_t e_jump(input logic link);
    outs_t o = base();
    o.pcw = 1'b1; o.pcsrc = 2'd2; o.jal = link; o.rw = link;
    return o;
  endfunction

  function automatic outs_t e_halt();
    outs_t o = base();
    o.hlt = 1'b1;
    return o;
  endfunction

  // Queue one cycle's expectation, then advance to just after the next edge.
  task automatic expect_cyc(input string nm, input outs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // FETCH and DECODE, then scramble IR to prove later states use latched fields.
  task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input string nm);
    ir_opcode = op;
    ir_funct  = fn;
    expect_cyc({nm, "_fetch"}, e_fetch());
    expect_cyc({nm, "_decode"}, e_decode());
    ir_opcode = op ^ 6'h3F;
    ir_funct  = fn ^ 6'h3F;
  endtask

  task automatic r_type(input logic [5:0] fn, input logic [3:0] sel, input string nm);
    begin_instr(6'h00, fn, nm);
    expect_cyc({nm, "_exec"}, e_exec_r(sel));
    expect_cyc({nm, "_wb"}, e_rwb(2'd0));
  endtask

  task automatic i_type(input logic [5:0] op, input logic [3:0] sel, input logic sgn,
                        input string nm);
    begin_instr(op, 6'h15, nm);
    expect_cyc({nm, "_exec"}, e_exec_i(sel, sgn));
    expect_cyc({nm, "_wb"}, e_wb_rt(1'b0));
  endtask

  task automatic branch(input logic [5:0] op, input logic az, input logic bt,
                        input logic [3:0] sel, input logic ok, input string nm);
    alu_zero     = az;
    branch_taken = bt;
    begin_instr(op, 6'h00, nm);
    expect_cyc({nm, "_branch"}, e_branch(sel, ok));
  endtask

  initial begin : monitor
    outs_t e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end else if (done) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_cyc("reset_idle", base());
    rst_n = 1'b1;

    r_type(6'h21, C_ADD_U, "addu");
    r_type(6'h23, C_SUB_U, "subu");
    r_type(6'h00, C_SLL,   "sll");
    r_type(6'h03, C_SRA,   "sra");
    r_type(6'h2B, C_SLTU,  "sltu");
    r_type(6'h25, C_OR,    "or");

    begin_instr(6'h00, 6'h19, "multu");
    expect_cyc("multu_exec", e_exec_r(C_MUL_U));
    expect_cyc("multu_wb", e_mult_wb());
    begin_instr(6'h00, 6'h10, "mfhi");
    expect_cyc("mfhi_exec", e_exec_r(C_ADD_U));
    expect_cyc("mfhi_wb", e_rwb(2'd2));
    begin_instr(6'h00, 6'h12, "mflo");
    expect_cyc("mflo_exec", e_exec_r(C_ADD_U));
    expect_cyc("mflo_wb", e_rwb(2'd1));
    begin_instr(6'h00, 6'h08, "jr");
    expect_cyc("jr_exec", e_jr());

    i_type(6'h09, C_ADD_U, 1'b1, "addiu");
    i_type(6'h0C, C_AND,   1'b0, "andi");
    i_type(6'h0E, C_XOR,   1'b0, "xori");
    i_type(6'h0A, C_SLT,   1'b1, "slti");
    i_type(6'h10, C_SUB_U, 1'b1, "subi");

    begin_instr(6'h23, 6'h00, "lw");
    expect_cyc("lw_addr", e_mem_addr());
    expect_cyc("lw_rd", e_mem(1'b1, 1'b0));
    expect_cyc("lw_wait", e_mem(1'b0, 1'b0));
    expect_cyc("lw_wb", e_wb_rt(1'b1));
    begin_instr(6'h2B, 6'h00, "sw");
    expect_cyc("sw_addr", e_mem_addr());
    expect_cyc("sw_wr", e_mem(1'b0, 1'b1));

    branch(6'h04, 1'b1, 1'b0, C_SUB_U, 1'b1, "beq_z1");
    branch(6'h04, 1'b0, 1'b1, C_SUB_U, 1'b0, "beq_z0");
    branch(6'h05, 1'b0, 1'b0, C_SUB_U, 1'b1, "bne_z0");
    branch(6'h05, 1'b1, 1'b1, C_SUB_U, 1'b0, "bne_z1");
    branch(6'h06, 1'b1, 1'b0, C_BLEZ,  1'b0, "blez_t0");
    branch(6'h07, 1'b0, 1'b1, C_BGTZ,  1'b1, "bgtz_t1");
    branch(6'h07, 1'b1, 1'b0, C_BGTZ,  1'b0, "bgtz_t0");

    begin_instr(6'h02, 6'h00, "j");
    expect_cyc("j_jump", e_jump(1'b0));
    begin_instr(6'h03, 6'h00, "jal");
    expect_cyc("jal_jump", e_jump(1'b1));

    begin_instr(6'h20, 6'h00, "nop");

    begin_instr(6'h23, 6'h00, "lw_rst");
    expect_cyc("lw_rst_addr", e_mem_addr());
    checks++;
    if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin
      failures++;
      $display("FAIL memrd_before_rst: mem_read=%b i_or_d=%b", mem_read, i_or_d);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || i_or_d !== 1'b0 || reg_write !== 1'b0 ||
        mem_to_reg !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_memrd: mem_read=%b i_or_d=%b reg_write=%b mem_to_reg=%b",
               mem_read, i_or_d, reg_write, mem_to_reg);
    end
    expect_cyc("rst_mid_memrd", base());
    rst_n = 1'b1;
    r_type(6'h21, C_ADD_U, "addu_after_rst");

    begin_instr(6'h3F, 6'h00, "halt");
    for (int i = 0; i < 100; i++) begin
      ir_opcode = 6'($urandom_range(0, 63));
      expect_cyc("halt_hold", e_halt());
      checks++;
      if (halted !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0 ||
          pc_write !== 1'b0) begin
        failures++;
        $display("FAIL halt_direct %0d: halted=%b reg_write=%b mem_write=%b pc_write=%b",
                 i, halted, reg_write, mem_write, pc_write);
      end
    end
    rst_n = 1'b0;
    expect_cyc("halt_reset", base());
    rst_n = 1'b1;
    r_type(6'h26, C_XOR, "xor_after_halt");

    done = 1'b1;
  end

endmodule

// File: doc/mips_ctrl.md
MIPS_CTRL -- requirements
Module: mips_ctrl

Interface
REQ-001 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- ir_opcode, in, 6: IR[31:26].
- ir_funct, in, 6: IR[5:0].
- branch_taken, in, 1: ALU BLEZ/BGTZ flag.
- alu_zero, in, 1: ALU result == 0.
- opsel, out, alu_sel_t: ALU operation.
- alu_src_a, out, 1: 0 = PC, 1 = reg A.
- alu_src_b, out, 2: 0 = reg B, 1 = const 4, 2 = sign/zero-extended imm, 3 = imm<<2.
- is_signed, out, 1: sign-extend imm.
- pc_write, out, 1: unconditional PC load.
- pc_write_cond, out, 1: branch PC load (gated by branch_ok).
- branch_ok, out, 1: branch condition met.
- pc_source, out, 2: 0 = ALU, 1 = ALU_OUT reg, 2 = jump target.
- i_or_d, out, 1: 0 = PC addresses memory, 1 = ALU_OUT.
- mem_read, out, 1: memory read strobe.
- mem_write, out, 1: memory write strobe.
- ir_write, out, 1: load IR.
- reg_write, out, 1: regfile write enable.
- reg_dst, out, 1: 0 = rt, 1 = rd.
- mem_to_reg, out, 1: writeback from MDR.
- jump_and_link, out, 1: write PC+4 to r31.
- alu_lo_hi, out, 2: writeback mux, 0 = ALU_OUT, 1 = LO, 2 = HI.
- hi_en, out, 1: load HI.
- lo_en, out, 1: load LO.
- halted, out, 1: HALT state reached.
REQ-002 Clock and reset: one clock, clk; reset rst_n, asynchronous, active-low.

Function
REQ-003 Moore FSM; all outputs decode from current state plus latched opcode/funct only; no output depends combinationally on ir_opcode.
REQ-004 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_RD_WAIT, MEM_WB, MEM_WR, R_WB, I_WB, MULT_WB, BRANCH, JUMP, HALT.
REQ-005 FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=1, opsel=C_ADD_U, pc_write=1, pc_source=0; next DECODE.
REQ-006 DECODE: opsel=C_ADD_U, alu_src_b=3 (branch target into ALU_OUT); opcode/funct latched here.
REQ-007 From DECODE: 0x00 -> EXEC_R; 0x23 or 0x2B -> MEM_ADDR; 0x04-0x07 -> BRANCH; 0x02/0x03 -> JUMP; 0x3F -> HALT; 0x09-0x0E or 0x10 -> EXEC_I; any other opcode -> FETCH (NOP).
REQ-008 R funct -> opsel: 0x21 ADD_U; 0x23 SUB_U; 0x18 MULT; 0x19 MUL_U; 0x24 AND; 0x25 OR; 0x26 XOR; 0x02 SRL; 0x00 SLL; 0x03 SRA; 0x2A SLT; 0x2B SLTU.
REQ-009 EXEC_R -> R_WB, except: MULT/MULTU -> MULT_WB; mfhi (0x10)/mflo (0x12) -> R_WB with alu_lo_hi 2/1; jr (0x08) -> FETCH with pc_write=1, pc_source=0, alu_src_a=1, opsel=C_ADD_U, alu_src_b=1 with constant treated as 0 (alu_src_b=0 against r0 unacceptable).
REQ-010 R_WB: reg_write=1, reg_dst=1; next FETCH. MULT_WB: hi_en=lo_en=1, no reg_write; next FETCH.
REQ-011 EXEC_I: alu_src_a=1, alu_src_b=2. Opsel by opcode: 0x09 ADD_U; 0x10 SUB_U; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0A SLT; 0x0B SLTU. is_signed=1 except 0x0C-0x0E. Next I_WB (reg_write=1, reg_dst=0); then FETCH.
REQ-012 MEM_ADDR: ADD_U, signed imm. lw -> MEM_RD -> MEM_RD_WAIT -> MEM_WB (mem_to_reg=1, reg_write=1, reg_dst=0). sw -> MEM_WR (mem_write=1, i_or_d=1). i_or_d=1 throughout MEM_RD/MEM_RD_WAIT.
REQ-013 BRANCH: alu_src_a=1, pc_write_cond=1, pc_source=1. beq/bne: opsel=C_SUB_U, alu_src_b=0, branch_ok=alu_zero / !alu_zero. blez/bgtz: opsel=C_BLEZ/C_BGTZ, branch_ok=branch_taken. Next FETCH.
REQ-014 JUMP: pc_write=1, pc_source=2; jal also jump_and_link=1, reg_write=1. Next FETCH.
REQ-015 HALT is absorbing: all strobes 0, halted=1; exit only by reset.
REQ-016 Outside its stated states each strobe is 0; opsel defaults to C_ADD_U.
REQ-017 Latency: R/I = 4 cycles, lw = 6, sw = 4, branch/jump = 3.

Reset
REQ-018 rst_n low forces FETCH asynchronously, latched opcode/funct = 0, all strobes 0, halted=0; this holds mid-instruction with no partial writeback.
REQ-019 First rising edge after rst_n deassert performs FETCH actions.

Structure
REQ-020 alu_sel_t stays in alu_pkg. ctrl_state_t and opcode/funct localparams go in new ctrl_pkg.
REQ-021 Opsel decode goes in combinational sub-module alu_ctrl (inputs: state class, opcode, funct); FSM stays in mips_ctrl.

Verification
REQ-022 addu (op 0x00, funct 0x21) from reset -> FETCH, DECODE, EXEC_R (opsel=C_ADD_U), R_WB (reg_write=1, reg_dst=1), FETCH.
REQ-023 lw (0x23) -> MEM_RD and MEM_RD_WAIT with i_or_d=1; MEM_WB with mem_to_reg=1; 6 cycles total.
REQ-024 beq (0x04), alu_zero=1 -> pc_write_cond=1, branch_ok=1; alu_zero=0 -> branch_ok=0; next state FETCH in both cases.
REQ-025 bgtz (0x07), branch_taken=1 -> opsel=C_BGTZ, branch_ok=1.
REQ-026 multu (funct 0x19) -> MULT_WB with hi_en=lo_en=1, reg_write=0; mfhi next -> R_WB with alu_lo_hi=2.
REQ-027 rst_n low mid-MEM_RD -> immediately FETCH, all strobes 0. Opcode 0x3F -> halted=1 held for 100 cycles.
